pkt_meta_out_sched: RTL and testbench
=====================================

Name: pkt_meta_out_sched

Overview:
Output scheduler that sequences the packet buffer FIFO and the metadata FIFO behind the stream parser and deparser, and emits them as one ordered stream. Each packet (134b words, head/tail tagged) is released only when its metadata word is also available; the metadata is issued one cycle ahead of the packet's first word. The block resynchronises on malformed framing and truncates over-length packets, keeping packets and metadata paired 1:1.

Parameters:
META_WIDTH, 128, metadata word width
MAX_PKT_WORDS, 128, maximum 134b words per packet before truncation (>=2)
CNT_WIDTH, 32, width of statistics counters

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; synchronous, active-low
i_pkt_empty  in  1  packet FIFO empty (FWFT FIFO)
i_pkt_dout  in  134  packet FIFO head word; valid when !i_pkt_empty
o_pkt_rden  out  1  pop packet FIFO (combinational)
i_meta_empty  in  1  meta FIFO empty (FWFT FIFO)
i_meta_dout  in  META_WIDTH  meta FIFO head word
o_meta_rden  out  1  pop meta FIFO (combinational)
i_out_ready  in  1  downstream can accept
o_meta_valid  out  1  metadata strobe (registered)
o_meta  out  META_WIDTH  metadata
o_data_valid  out  1  packet word strobe (registered)
o_data  out  134  packet word; [133:132] tag, [131:128] valid bytes, [127:0] data
o_pkt_cnt  out  CNT_WIDTH  packets emitted
o_err_cnt  out  CNT_WIDTH  framing/length errors

Behaviour:
- Tags: 2'b01 head, 2'b10 tail, 2'b00 middle, 2'b11 single-word packet (head+tail).
- Reset (i_rst_n low at clock edge): state IDLE; word_cnt, o_pkt_cnt, o_err_cnt = 0; o_meta_valid, o_data_valid = 0; o_meta, o_data = 0. Applies mid-packet; the partial packet is abandoned. FIFOs are reset by the same signal externally.
- Both FIFOs are first-word-fall-through: the head word is visible before the pop; a pop consumes it in the same cycle.
- States: IDLE, SEND, DROP.
- IDLE, condition !i_pkt_empty && !i_meta_empty && i_out_ready:
  - Head tag 01/11: pop meta; o_meta <= i_meta_dout and o_meta_valid = 1 next cycle; word_cnt = 0; go to SEND. The packet word is not popped.
  - Head tag 00/10: pop the packet word only (discard it); o_err_cnt++; stay in IDLE. Meta is retained.
- IDLE, otherwise: no pops.
- SEND, each cycle with !i_pkt_empty && i_out_ready:
  - Pop one word. o_data <= word and o_data_valid = 1 next cycle. word_cnt++.
  - Word with tag 10, or first word (word_cnt==0) with tag 11: o_pkt_cnt++; go to IDLE.
  - Non-first word with tag 01/11: not popped; o_err_cnt++; go to IDLE without emitting a tail. That word starts the next packet.
  - Word number MAX_PKT_WORDS not a tail: emitted with tag forced to 2'b10; o_pkt_cnt++; o_err_cnt++; go to DROP.
- SEND, stalled (empty or !i_out_ready): no pop; o_data_valid = 0.
- DROP: pop whenever !i_pkt_empty, ignoring i_out_ready; discard words; no output. Leave for IDLE after popping a word with tag 10 or 11.
- Timing: pop -> o_data_valid latency 1 cycle. i_out_ready low stops pops in that cycle, so downstream sees at most 1 further word. Full-rate 1 word/cycle within a packet; 1 bubble per packet (the meta cycle).
- o_meta_valid is a 1-cycle pulse, at least 1 cycle before the packet's first o_data_valid.
- Counters saturate at all-ones; no wrap.
- o_pkt_rden and o_meta_rden are never asserted while their FIFO is empty.

Test Plan:
- Meta 0x...A5 + 3-word packet (01,00,10), ready=1: meta pop at cycle t, o_meta_valid at t+1, o_data_valid t+2..t+4 with tags 01,00,10; o_pkt_cnt=1, o_err_cnt=0.
- Two single-word packets (tag 11), 2 metas: pattern meta, data, meta, data over 4 cycles; o_pkt_cnt=2.
- Stray middle word (00) before a good 2-word packet: stray dropped with no output; o_err_cnt=1; good packet paired with the first meta; o_pkt_cnt=1.
- MAX_PKT_WORDS=4, 6-word packet followed by a 2-word packet: 4 words out, the 4th with tag 10; 2 words silently dropped; next packet intact; o_pkt_cnt=2, o_err_cnt=1.
- i_out_ready toggling 1/0 and empty gaps during a 5-word packet: all 5 words emitted in order, none duplicated, o_data_valid=0 in each cycle after ready=0.
- Reset asserted after the 2nd word of a packet: next cycle all outputs and counters are 0 and state is IDLE; after reset, a fresh meta+packet passes normally.

Source files
------------

// File: rtl/pkt_meta_out_sched.sv
// Purpose: pairs each packet from the packet FIFO with one metadata word and emits meta, then the packet words, as one stream.
// Latency: one cycle from FIFO pop to o_meta_valid / o_data_valid; the meta cycle costs one bubble per packet.
// Backpressure: i_out_ready low blocks pops in that cycle, so at most one more word appears after ready drops.
//
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_pkt_empty/i_pkt_dout       packet FIFO head (first-word-fall-through), o_pkt_rden pops it
//   i_meta_empty/i_meta_dout     metadata FIFO head (first-word-fall-through), o_meta_rden pops it
//   i_out_ready                  downstream accepts a word this cycle
//   o_meta_valid/o_meta          registered metadata strobe and word
//   o_data_valid/o_data          registered packet word strobe and word ([133:132] tag, [131:128] bytes, [127:0] data)
//   o_pkt_cnt/o_err_cnt          saturating packet and framing/length error counters
module pkt_meta_out_sched #(
    parameter int META_WIDTH    = 128,
    parameter int MAX_PKT_WORDS = 128,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pkt_empty,
    input  logic [133:0]          i_pkt_dout,
    output logic                  o_pkt_rden,
    input  logic                  i_meta_empty,
    input  logic [META_WIDTH-1:0] i_meta_dout,
    output logic                  o_meta_rden,
    input  logic                  i_out_ready,
    output logic                  o_meta_valid,
    output logic [META_WIDTH-1:0] o_meta,
    output logic                  o_data_valid,
    output logic [133:0]          o_data,
    output logic [CNT_WIDTH-1:0]  o_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    // Word counter must hold MAX_PKT_WORDS itself after a truncation.
    localparam int WCW = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [WCW-1:0] LAST_CNT = WCW'(MAX_PKT_WORDS - 1);
    localparam logic [1:0]     TAG_TAIL = 2'b10;

    typedef struct packed {
        logic [1:0]   tag;
        logic [3:0]   nbytes;
        logic [127:0] dat;
    } pkt_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DROP
    } state_t;

    state_t                state;
    logic [WCW-1:0]        word_cnt;
    logic                  meta_vld;
    logic [META_WIDTH-1:0] meta_dat;
    logic                  data_vld;
    pkt_word_t             data_dat;
    logic [CNT_WIDTH-1:0]  pkt_cnt;
    logic [CNT_WIDTH-1:0]  err_cnt;

    pkt_word_t head;
    logic      head_is_start;  // tag 01 or 11
    logic      head_is_end;    // tag 10 or 11
    logic      send_go;
    logic      idle_go;
    logic      send_resync;
    logic      send_last_slot;

    assign head          = pkt_word_t'(i_pkt_dout);
    assign head_is_start = head.tag[0];
    assign head_is_end   = head.tag[1];

    assign send_go = !i_pkt_empty && i_out_ready;
    assign idle_go = send_go && !i_meta_empty;

    // A start tag after the first word means the previous packet lost its
    // tail; that word is left in the FIFO so it can open the next packet.
    assign send_resync = (word_cnt != '0) && head_is_start;

    // Next popped word would be word number MAX_PKT_WORDS.
    assign send_last_slot = (word_cnt == LAST_CNT);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Pops are combinational so a FWFT head word is consumed in the same
    // cycle it is acted on. Every pop is qualified by its FIFO's !empty.
    always_comb begin
        o_pkt_rden  = 1'b0;
        o_meta_rden = 1'b0;
        case (state)
            IDLE: begin
                if (idle_go) begin
                    if (head_is_start) begin
                        o_meta_rden = 1'b1;
                    end else begin
                        // Stray middle/tail word outside a packet: discard.
                        o_pkt_rden = 1'b1;
                    end
                end
            end
            SEND: begin
                if (send_go && !send_resync) begin
                    o_pkt_rden = 1'b1;
                end
            end
            DROP: begin
                // Draining the over-length remainder does not wait for downstream.
                o_pkt_rden = !i_pkt_empty;
            end
            default: begin
                o_pkt_rden  = 1'b0;
                o_meta_rden = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            meta_vld <= 1'b0;
            meta_dat <= '0;
            data_vld <= 1'b0;
            data_dat <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            // Strobes are single-cycle; data/meta registers hold their last value.
            meta_vld <= 1'b0;
            data_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_go) begin
                        if (head_is_start) begin
                            // Meta goes out first; the head word stays in
                            // the FIFO and is popped from SEND next cycle.
                            meta_dat <= i_meta_dout;
                            meta_vld <= 1'b1;
                            word_cnt <= '0;
                            state    <= SEND;
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end
                SEND: begin
                    if (send_go) begin
                        if (send_resync) begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= IDLE;
                        end else begin
                            data_vld <= 1'b1;
                            word_cnt <= word_cnt + WCW'(1);
                            if (head_is_end) begin
                                // Tail, or a single-word packet on the first word.
                                data_dat <= head;
                                pkt_cnt  <= sat_inc(pkt_cnt);
                                state    <= IDLE;
                            end else if (send_last_slot) begin
                                // Over-length: close the packet here with a
                                // forced tail and discard the rest in DROP.
                                data_dat <= '{tag: TAG_TAIL, nbytes: head.nbytes, dat: head.dat};
                                pkt_cnt  <= sat_inc(pkt_cnt);
                                err_cnt  <= sat_inc(err_cnt);
                                state    <= DROP;
                            end else begin
                                data_dat <= head;
                            end
                        end
                    end
                end
                DROP: begin
                    if (!i_pkt_empty && head_is_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_meta_valid = meta_vld;
    assign o_meta       = meta_dat;
    assign o_data_valid = data_vld;
    assign o_data       = data_dat;
    assign o_pkt_cnt    = pkt_cnt;
    assign o_err_cnt    = err_cnt;

endmodule

// File: tb/tb_pkt_meta_out_sched.sv
// Purpose: exercises pkt_meta_out_sched with directed and random packet/meta streams against a stream-level reference.
// Latency: expects outputs one cycle after each pop; meta strictly before its packet's words.
// Backpressure: randomises i_out_ready and FIFO empty gaps; models FWFT FIFOs with queues.
module tb_pkt_meta_out_sched;

    localparam int MW   = 128;
    localparam int MAXW = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pkt_empty;
    logic [133:0]   pkt_dout;
    logic           pkt_rden;
    logic           meta_empty;
    logic [MW-1:0]  meta_dout;
    logic           meta_rden;
    logic           out_ready;
    logic           meta_valid;
    logic [MW-1:0]  meta;
    logic           data_valid;
    logic [133:0]   data;
    logic [CW-1:0]  pkt_cnt;
    logic [CW-1:0]  err_cnt;

    always #5 clk = ~clk;

    pkt_meta_out_sched #(
        .META_WIDTH    (MW),
        .MAX_PKT_WORDS (MAXW),
        .CNT_WIDTH     (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pkt_empty  (pkt_empty),
        .i_pkt_dout   (pkt_dout),
        .o_pkt_rden   (pkt_rden),
        .i_meta_empty (meta_empty),
        .i_meta_dout  (meta_dout),
        .o_meta_rden  (meta_rden),
        .i_out_ready  (out_ready),
        .o_meta_valid (meta_valid),
        .o_meta       (meta),
        .o_data_valid (data_valid),
        .o_data       (data),
        .o_pkt_cnt    (pkt_cnt),
        .o_err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic         is_meta;
        logic [133:0] val;
    } ev_t;

    logic [133:0]  in_w[$];
    logic [MW-1:0] in_m[$];
    logic [133:0]  pq[$];
    logic [MW-1:0] mq[$];
    ev_t           exp_q[$];
    ev_t           got_q[$];
    int            got_cyc[$];
    int            exp_pkt, exp_err, exp_wleft, exp_mleft;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] mkw(input logic [1:0] t);
        logic [133:0] w;
        w[133:132] = t;
        w[131:128] = 4'($urandom_range(0, 15));
        w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
        return w;
    endfunction

    function automatic logic [MW-1:0] mkm();
        logic [MW-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        return m;
    endfunction

    // Stream-level reference: walks the input word list packet by packet and
    // lists the output events in order plus final counters / leftovers.
    task automatic build_model();
        int wi = 0;
        int mi = 0;
        int n;
        int nw = in_w.size();
        int nm = in_m.size();
        int pk = 0;
        int er = 0;
        bit stop = 0;
        logic [133:0] w;
        logic [1:0]   t;
        ev_t ev;
        exp_q.delete();
        while (!stop && wi < nw && mi < nm) begin
            t = in_w[wi][133:132];
            if (t == 2'b00 || t == 2'b10) begin
                er++;
                wi++;
                continue;
            end
            ev.is_meta = 1'b1;
            ev.val     = {6'b0, in_m[mi]};
            exp_q.push_back(ev);
            mi++;
            n = 0;
            forever begin
                if (wi >= nw) begin
                    stop = 1;
                    break;
                end
                w = in_w[wi];
                t = w[133:132];
                if (n > 0 && (t == 2'b01 || t == 2'b11)) begin
                    er++;
                    break;
                end
                n++;
                wi++;
                ev.is_meta = 1'b0;
                if (t == 2'b10 || (n == 1 && t == 2'b11)) begin
                    ev.val = w;
                    exp_q.push_back(ev);
                    pk++;
                    break;
                end
                if (n == MAXW) begin
                    w[133:132] = 2'b10;
                    ev.val = w;
                    exp_q.push_back(ev);
                    pk++;
                    er++;
                    while (wi < nw) begin
                        t = in_w[wi][133:132];
                        wi++;
                        if (t == 2'b10 || t == 2'b11) break;
                    end
                    break;
                end
                ev.val = w;
                exp_q.push_back(ev);
            end
        end
        exp_pkt   = (pk > CMAX) ? CMAX : pk;
        exp_err   = (er > CMAX) ? CMAX : er;
        exp_wleft = nw - wi;
        exp_mleft = nm - mi;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        pkt_empty  = 1'b1;
        meta_empty = 1'b1;
        out_ready  = 1'b0;
        pkt_dout   = '0;
        meta_dout  = '0;
        pq.delete();
        mq.delete();
        @(posedge clk);
        #1;
        check("rst_meta_valid", 134'(meta_valid), 134'(0));
        check("rst_data_valid", 134'(data_valid), 134'(0));
        check("rst_meta",       134'(meta),       134'(0));
        check("rst_data",       data,             134'(0));
        check("rst_pkt_cnt",    134'(pkt_cnt),    134'(0));
        check("rst_err_cnt",    134'(err_cnt),    134'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input int rdy_pct, input int gap_pct, output bit busy);
        bit  rdy, gap, pp, pm;
        ev_t ev;
        @(negedge clk);
        rdy = int'($urandom_range(0, 99)) < rdy_pct;
        gap = int'($urandom_range(0, 99)) < gap_pct;
        out_ready  = rdy;
        pkt_empty  = (pq.size() == 0) || gap;
        pkt_dout   = (pq.size() != 0) ? pq[0] : '0;
        meta_empty = (mq.size() == 0);
        meta_dout  = (mq.size() != 0) ? mq[0] : '0;
        #1;
        pp = pkt_rden;
        pm = meta_rden;
        if (pkt_empty)  check("pkt_rden_while_empty",  134'(pp), 134'(0));
        if (meta_empty) check("meta_rden_while_empty", 134'(pm), 134'(0));
        @(posedge clk);
        if (pp && pq.size() != 0) void'(pq.pop_front());
        if (pm && mq.size() != 0) void'(mq.pop_front());
        #1;
        cyc++;
        if (meta_valid) begin
            ev.is_meta = 1'b1;
            ev.val     = {6'b0, meta};
            got_q.push_back(ev);
            got_cyc.push_back(cyc);
        end
        if (data_valid) begin
            ev.is_meta = 1'b0;
            ev.val     = data;
            got_q.push_back(ev);
            got_cyc.push_back(cyc);
        end
        if (!rdy)       check("data_valid_after_stall", 134'(data_valid), 134'(0));
        if (meta_valid) check("meta_data_same_cycle",   134'(data_valid), 134'(0));
        busy = pp || pm || meta_valid || data_valid;
    endtask

    task automatic run_scenario(input string name, input int rdy_pct, input int gap_pct,
                                input bit strict, input bit with_reset);
        int idle  = 0;
        int guard = 0;
        int n;
        bit busy;
        if (with_reset) do_reset();
        pq = in_w;
        mq = in_m;
        build_model();
        got_q.delete();
        got_cyc.delete();
        while (idle < 24 && guard < 4000) begin
            cycle(rdy_pct, gap_pct, busy);
            idle = busy ? 0 : idle + 1;
            guard++;
        end
        check($sformatf("%s_settled", name), 134'(idle >= 24), 134'(1));
        check($sformatf("%s_event_count", name), 134'(got_q.size()), 134'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d_kind", name, i), 134'(got_q[i].is_meta), 134'(exp_q[i].is_meta));
            check($sformatf("%s_ev%0d_val", name, i), got_q[i].val, exp_q[i].val);
        end
        if (strict) begin
            for (int i = 1; i < got_cyc.size(); i++) begin
                check($sformatf("%s_ev%0d_back_to_back", name, i),
                      134'(got_cyc[i] - got_cyc[i-1]), 134'(1));
            end
        end
        check($sformatf("%s_pkt_cnt", name),    134'(pkt_cnt),   134'(exp_pkt));
        check($sformatf("%s_err_cnt", name),    134'(err_cnt),   134'(exp_err));
        check($sformatf("%s_pkt_left", name),   134'(pq.size()), 134'(exp_wleft));
        check($sformatf("%s_meta_left", name),  134'(mq.size()), 134'(exp_mleft));
    endtask

    task automatic gen_random(input int npkts);
        int len;
        in_w.delete();
        in_m.delete();
        for (int p = 0; p < npkts; p++) begin
            if ($urandom_range(0, 9) == 0) in_w.push_back(mkw($urandom_range(0, 1) ? 2'b00 : 2'b10));
            len = $urandom_range(1, 6);
            if (len == 1) begin
                in_w.push_back(mkw(2'b11));
            end else begin
                in_w.push_back(mkw(2'b01));
                for (int k = 1; k < len - 1; k++) in_w.push_back(mkw(2'b00));
                if ($urandom_range(0, 9) != 0) in_w.push_back(mkw(2'b10));
                else in_w.push_back(mkw(2'b00));
            end
            in_m.push_back(mkm());
        end
    endtask

    initial begin
        int   guard;
        bit   busy;
        logic [MW-1:0] m;

        rst_n      = 1'b0;
        pkt_empty  = 1'b1;
        meta_empty = 1'b1;
        out_ready  = 1'b0;
        pkt_dout   = '0;
        meta_dout  = '0;

        // Meta ending A5 plus a 3-word packet at full rate.
        in_w.delete(); in_m.delete();
        m = mkm(); m[7:0] = 8'hA5;
        in_m.push_back(m);
        in_w.push_back(mkw(2'b01)); in_w.push_back(mkw(2'b00)); in_w.push_back(mkw(2'b10));
        run_scenario("three_word", 100, 0, 1, 1);

        // Two single-word packets: meta, data, meta, data.
        in_w.delete(); in_m.delete();
        in_w.push_back(mkw(2'b11)); in_w.push_back(mkw(2'b11));
        in_m.push_back(mkm()); in_m.push_back(mkm());
        run_scenario("two_single", 100, 0, 1, 1);

        // Stray middle word ahead of a good 2-word packet.
        in_w.delete(); in_m.delete();
        in_w.push_back(mkw(2'b00)); in_w.push_back(mkw(2'b01)); in_w.push_back(mkw(2'b10));
        in_m.push_back(mkm());
        run_scenario("stray_mid", 100, 0, 0, 1);

        // 6-word packet truncated at MAXW, then a 2-word packet.
        in_w.delete(); in_m.delete();
        in_w.push_back(mkw(2'b01));
        for (int k = 0; k < 4; k++) in_w.push_back(mkw(2'b00));
        in_w.push_back(mkw(2'b10));
        in_w.push_back(mkw(2'b01)); in_w.push_back(mkw(2'b10));
        in_m.push_back(mkm()); in_m.push_back(mkm());
        run_scenario("truncate", 100, 0, 0, 1);

        // Missing tail: second head resynchronises.
        in_w.delete(); in_m.delete();
        in_w.push_back(mkw(2'b01)); in_w.push_back(mkw(2'b00));
        in_w.push_back(mkw(2'b01)); in_w.push_back(mkw(2'b10));
        in_m.push_back(mkm()); in_m.push_back(mkm());
        run_scenario("resync", 100, 0, 0, 1);

        // 5-word packet with ready toggling and empty gaps.
        in_w.delete(); in_m.delete();
        in_w.push_back(mkw(2'b01));
        for (int k = 0; k < 3; k++) in_w.push_back(mkw(2'b00));
        in_w.push_back(mkw(2'b10));
        in_m.push_back(mkm());
        run_scenario("stall_gap", 50, 30, 0, 1);

        // Reset after the second word of a packet, then a fresh packet.
        do_reset();
        in_w.delete(); in_m.delete();
        in_w.push_back(mkw(2'b01));
        for (int k = 0; k < 3; k++) in_w.push_back(mkw(2'b00));
        in_w.push_back(mkw(2'b10));
        in_m.push_back(mkm());
        pq = in_w;
        mq = in_m;
        got_q.delete();
        got_cyc.delete();
        guard = 0;
        while (got_q.size() < 3 && guard < 50) begin
            cycle(100, 0, busy);
            guard++;
        end
        check("rst_mid_two_words_seen", 134'(got_q.size()), 134'(3));
        do_reset();
        in_w.delete(); in_m.delete();
        in_w.push_back(mkw(2'b01)); in_w.push_back(mkw(2'b10));
        in_m.push_back(mkm());
        run_scenario("after_reset", 100, 0, 1, 0);

        // Random streams; the long one drives the 4-bit counters to saturation.
        gen_random(30);
        run_scenario("rand_long", 70, 20, 0, 1);
        gen_random(12);
        run_scenario("rand_full_rate", 100, 0, 0, 1);
        gen_random(15);
        run_scenario("rand_slow", 30, 40, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
